// File: rtl/axi_elastic_buffer.sv
// DEPTH-entry elastic buffer for one AXI4-Lite channel with occupancy, almost-full and flush.
// Optional stall counter on stall_cnt_o is built only when AXI_EB_STALL_CNT_EN is defined.
module axi_elastic_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int AF_THRESH  = 3
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         flush_i,
    input  logic [DATA_WIDTH-1:0]        s_data_i,
    input  logic                         s_valid_i,
    output logic                         s_ready_o,
    output logic [DATA_WIDTH-1:0]        m_data_o,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         almost_full_o
`ifdef AXI_EB_STALL_CNT_EN
    ,
    output logic [31:0]                  stall_cnt_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         level_q;
    logic [LW-1:0]         next_level;
    logic                  push;
    logic                  pop;

    assign push = s_valid_i & s_ready_o;
    assign pop  = m_valid_o & m_ready_i;

    // Flags are derived from the next occupancy so they can be registered,
    // which keeps s_ready_o free of any path from m_ready_i.
    always_comb begin
        next_level = level_q;
        if (flush_i) begin
            next_level = '0;
        end else if (push && !pop) begin
            next_level = level_q + 1'b1;
        end else if (pop && !push) begin
            next_level = level_q - 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level_q       <= '0;
            s_ready_o     <= 1'b1;
            m_valid_o     <= 1'b0;
            almost_full_o <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            level_q       <= next_level;
            s_ready_o     <= (next_level != LW'(DEPTH));
            m_valid_o     <= (next_level != '0);
            almost_full_o <= (next_level >= LW'(AF_THRESH));
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= s_data_i;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    assign m_data_o = mem[rd_ptr];
    assign level_o  = level_q;

`ifdef AXI_EB_STALL_CNT_EN
    // Upstream back-pressure cycles, saturating rather than wrapping.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stall_cnt_o <= '0;
        end else if (flush_i) begin
            stall_cnt_o <= '0;
        end else if (s_valid_i && !s_ready_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_elastic_buffer.sv
// Directed self-checking bench for axi_elastic_buffer (DEPTH=4, AF_THRESH=3, 32-bit data).
module tb_axi_elastic_buffer;

    logic        aclk;
    logic        aresetn;
    logic        flush_i;
    logic [31:0] s_data_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [31:0] m_data_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [2:0]  level_o;
    logic        almost_full_o;
`ifdef AXI_EB_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    axi_elastic_buffer #(
        .DATA_WIDTH(32),
        .DEPTH(4),
        .AF_THRESH(3)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .flush_i(flush_i),
        .s_data_i(s_data_i),
        .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o),
        .m_data_o(m_data_o),
        .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i),
        .level_o(level_o),
        .almost_full_o(almost_full_o)
`ifdef AXI_EB_STALL_CNT_EN
        ,
        .stall_cnt_o(stall_cnt_o)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i   = 1'b0;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        m_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        s_valid_i = 1'b1;
        s_data_i  = 32'h11;
        step();
        s_data_i  = 32'h22;
        step();
        #2;
        aresetn = 1'b0;
        #1;
        total++;
        if (m_valid_o !== 1'b0 || s_ready_o !== 1'b1 || level_o !== 3'd0 ||
            almost_full_o !== 1'b0 || m_data_o !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_async: valid=%b ready=%b level=%0d af=%b data=%h, required 0 1 0 0 0",
                     m_valid_o, s_ready_o, level_o, almost_full_o, m_data_o);
        end
        step();
        total++;
        if (m_valid_o !== 1'b0 || s_ready_o !== 1'b1 || level_o !== 3'd0) begin
            bad++;
            $display("[TB] FAIL reset_held: valid=%b ready=%b level=%0d, required 0 1 0",
                     m_valid_o, s_ready_o, level_o);
        end
        idle_inputs();
        aresetn = 1'b1;
        step();
    endtask

    task automatic test_fill();
        idle_inputs();
        s_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data_i = 32'hA0 + i;
            step();
            total++;
            if (level_o !== 3'(i + 1) || m_valid_o !== 1'b1 || m_data_o !== 32'hA0 ||
                almost_full_o !== (i >= 2) || s_ready_o !== (i != 3)) begin
                bad++;
                $display("[TB] FAIL fill_%0d: level=%0d valid=%b data=%h af=%b ready=%b, required %0d 1 000000a0 %b %b",
                         i, level_o, m_valid_o, m_data_o, almost_full_o, s_ready_o,
                         i + 1, (i >= 2), (i != 3));
            end
        end
        // Push attempt while full must be refused and head must hold.
        s_data_i = 32'hEE;
        step();
        total++;
        if (level_o !== 3'd4 || s_ready_o !== 1'b0 || m_data_o !== 32'hA0) begin
            bad++;
            $display("[TB] FAIL fill_hold: level=%0d ready=%b data=%h, required 4 0 000000a0",
                     level_o, s_ready_o, m_data_o);
        end
        s_valid_i = 1'b0;
    endtask

    task automatic test_drain();
        m_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (m_valid_o !== 1'b1 || m_data_o !== 32'hA0 + i) begin
                bad++;
                $display("[TB] FAIL drain_%0d: valid=%b data=%h, required 1 %h",
                         i, m_valid_o, m_data_o, 32'hA0 + i);
            end
            step();
            if (i == 0) begin
                total++;
                if (s_ready_o !== 1'b1 || level_o !== 3'd3) begin
                    bad++;
                    $display("[TB] FAIL drain_ready: ready=%b level=%0d, required 1 3",
                             s_ready_o, level_o);
                end
            end
        end
        total++;
        if (m_valid_o !== 1'b0 || level_o !== 3'd0 || almost_full_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL drain_empty: valid=%b level=%0d af=%b, required 0 0 0",
                     m_valid_o, level_o, almost_full_o);
        end
        m_ready_i = 1'b0;
    endtask

    task automatic test_streaming();
        m_ready_i = 1'b1;
        s_valid_i = 1'b1;
        s_data_i  = 32'hB000;
        step();
        for (int k = 1; k <= 100; k++) begin
            total++;
            if (m_valid_o !== 1'b1 || m_data_o !== 32'hB000 + k - 1 || level_o !== 3'd1 ||
                s_ready_o !== 1'b1) begin
                bad++;
                $display("[TB] FAIL stream_%0d: valid=%b data=%h level=%0d ready=%b, required 1 %h 1 1",
                         k, m_valid_o, m_data_o, level_o, s_ready_o, 32'hB000 + k - 1);
            end
            if (k < 100) begin
                s_data_i = 32'hB000 + k;
            end else begin
                s_valid_i = 1'b0;
            end
            step();
        end
        total++;
        if (m_valid_o !== 1'b0 || level_o !== 3'd0) begin
            bad++;
            $display("[TB] FAIL stream_end: valid=%b level=%0d, required 0 0", m_valid_o, level_o);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        idle_inputs();
        s_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data_i = 32'hC0 + i;
            step();
        end
        total++;
        if (level_o !== 3'd3 || almost_full_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL flush_pre: level=%0d af=%b, required 3 1", level_o, almost_full_o);
        end
        flush_i  = 1'b1;
        s_data_i = 32'hDD;
        step();
        flush_i   = 1'b0;
        s_valid_i = 1'b0;
        total++;
        if (level_o !== 3'd0 || m_valid_o !== 1'b0 || s_ready_o !== 1'b1 || almost_full_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_state: level=%0d valid=%b ready=%b af=%b, required 0 0 1 0",
                     level_o, m_valid_o, s_ready_o, almost_full_o);
        end
        m_ready_i = 1'b1;
        step();
        total++;
        if (m_valid_o !== 1'b0 || level_o !== 3'd0) begin
            bad++;
            $display("[TB] FAIL flush_no_output: valid=%b level=%0d data=%h, required 0 0",
                     m_valid_o, level_o, m_data_o);
        end
        // After a flush the buffer restarts cleanly from pointer zero.
        m_ready_i = 1'b0;
        s_valid_i = 1'b1;
        s_data_i  = 32'h5A;
        step();
        s_valid_i = 1'b0;
        total++;
        if (m_valid_o !== 1'b1 || m_data_o !== 32'h5A || level_o !== 3'd1) begin
            bad++;
            $display("[TB] FAIL flush_restart: valid=%b data=%h level=%0d, required 1 0000005a 1",
                     m_valid_o, m_data_o, level_o);
        end
        flush_i = 1'b1;
        step();
        idle_inputs();
    endtask

`ifdef AXI_EB_STALL_CNT_EN
    task automatic test_stall_cnt();
        idle_inputs();
        flush_i = 1'b1;
        step();
        flush_i   = 1'b0;
        s_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data_i = 32'hF0 + i;
            step();
        end
        s_valid_i = 1'b0;
        total++;
        if (stall_cnt_o !== 32'd0 || s_ready_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_pre: cnt=%0d ready=%b, required 0 0", stall_cnt_o, s_ready_o);
        end
        s_valid_i = 1'b1;
        repeat (10) step();
        s_valid_i = 1'b0;
        total++;
        if (stall_cnt_o !== 32'd10) begin
            bad++;
            $display("[TB] FAIL stall_count: cnt=%0d, required 10", stall_cnt_o);
        end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        total++;
        if (stall_cnt_o !== 32'd0) begin
            bad++;
            $display("[TB] FAIL stall_flush: cnt=%0d, required 0", stall_cnt_o);
        end
    endtask
`endif

    initial begin
        idle_inputs();
        aresetn = 1'b0;
        #23;
        aresetn = 1'b1;
        step();
        test_reset();
        test_fill();
        test_drain();
        test_streaming();
        test_flush();
`ifdef AXI_EB_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
